// File: rtl/sirali_cikarici_pkg.sv
// Shared definitions for the multi-cycle subtractor: FSM state encoding and
// the default operand/chunk widths also used by the adder benches.
package sirali_cikarici_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_CHUNK = 16;

endpackage

// File: rtl/sirali_cikarici_dilim.sv
// One CHUNK-bit slice of the subtractor: d = a - b - borrow, with borrow-out.
module cikarici_dilim #(
   parameter int CHUNK = 16
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             borrow,
   output logic [CHUNK-1:0] d,
   output logic             bo
);

   // One extra bit of headroom: the top bit of the wide result is the borrow.
   always_comb begin
      {bo, d} = {1'b0, a} - {1'b0, b} - (CHUNK + 1)'(borrow);
   end

endmodule

// File: rtl/sirali_cikarici.sv
// Multi-cycle unsigned subtractor: CHUNK bits per clock with a registered
// borrow chain and a start/busy/done handshake. difference = {borrow, bits}.
module sirali_cikarici
   import sirali_cikarici_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] number1,
   input  logic [WIDTH-1:0] number2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   difference
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("sirali_cikarici: CHUNK must divide WIDTH and lie in 1..WIDTH");
   end

   state_t           state, state_next;
   logic [WIDTH-1:0] a, b, acc, acc_next;
   logic             borrow, bo, last;
   logic [CW-1:0]    cnt;
   logic [31:0]      sh;
   logic [CHUNK-1:0] ca, cb, cd;

   // Chunks are written exactly once into a cleared accumulator, so OR-ing
   // the shifted slice is equivalent to a part-select write.
   always_comb begin
      sh       = 32'(cnt) * 32'(CHUNK);
      ca       = CHUNK'(a >> sh);
      cb       = CHUNK'(b >> sh);
      acc_next = acc | (WIDTH'(cd) << sh);
      last     = (cnt == CW'(NCHUNK - 1));
   end

   cikarici_dilim #(.CHUNK(CHUNK)) u_dilim (
      .a      (ca),
      .b      (cb),
      .borrow (borrow),
      .d      (cd),
      .bo     (bo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: if (start) state_next = ST_CALC;
         ST_CALC: if (last)  state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == ST_CALC);
      done = (state == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a          <= '0;
         b          <= '0;
         acc        <= '0;
         borrow     <= 1'b0;
         cnt        <= '0;
         difference <= '0;
      end else if (state == ST_IDLE && start) begin
         a      <= number1;
         b      <= number2;
         acc    <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
      end else if (state == ST_CALC) begin
         acc    <= acc_next;
         borrow <= bo;
         if (last) difference <= {bo, acc_next};
         else      cnt        <= cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_sirali_cikarici.sv
// Directed bench for sirali_cikarici with hand-computed expected differences.
module tb_sirali_cikarici;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [63:0] number1, number2;
   logic        busy, done;
   logic [64:0] difference;

   int n_cmp = 0;
   int n_bad = 0;

   sirali_cikarici #(.WIDTH(64), .CHUNK(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .number1    (number1),
      .number2    (number2),
      .busy       (busy),
      .done       (done),
      .difference (difference)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one operation and waits (bounded) for done; samples 1ns after edges.
   task automatic run_op(input logic [63:0] x, input logic [63:0] y,
                         output logic [64:0] res, output int busy_n,
                         output int done_n, output int overlap);
      bit seen = 0;
      busy_n = 0; done_n = 0; overlap = 0; res = 'x;
      number1 = x; number2 = y; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (busy) busy_n++;
         if (busy && done) overlap++;
         if (done) begin
            done_n++; seen = 1; res = difference;
         end else begin
            step();
         end
      end
   endtask

   task automatic check_op(input string name, input logic [63:0] x,
                           input logic [63:0] y, input logic [64:0] exp);
      logic [64:0] res;
      int bn, dn, ov;
      run_op(x, y, res, bn, dn, ov);
      n_cmp++;
      if (res !== exp) begin
         n_bad++; $display("FAIL %s result: got %h expected %h", name, res, exp);
      end
      n_cmp++;
      if (bn !== 4 || dn !== 1 || ov !== 0) begin
         n_bad++;
         $display("FAIL %s timing: busy=%0d done=%0d overlap=%0d expected 4/1/0", name, bn, dn, ov);
      end
      step();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL %s after_done: done=%b busy=%b expected 0/0", name, done, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; number1 = '0; number2 = '0;
      step(); step();
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || difference !== 65'd0) begin
         n_bad++;
         $display("FAIL reset: busy=%b done=%b diff=%h expected 0/0/0", busy, done, difference);
      end
      rst = 1'b0;
      step();
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL idle_no_start: busy=%b done=%b expected 0/0", busy, done);
      end
   endtask

   task automatic test_basic();
      check_op("sub_3_1", 64'd3, 64'd1, 65'd2);
      check_op("sub_1_2", 64'd1, 64'd2, 65'h1_FFFF_FFFF_FFFF_FFFF);
      check_op("chunk_borrow", 64'h0000_0000_0001_0000, 64'd1, 65'h0_0000_0000_0000_FFFF);
   endtask

   task automatic test_extremes();
      check_op("equal", 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 65'd0);
      check_op("zero_minus_max", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 65'h1_0000_0000_0000_0001);
   endtask

   task automatic test_ignore_start();
      logic [64:0] res = 'x;
      int dn = 0;
      number1 = 64'd10; number2 = 64'd4; start = 1'b1;
      step();
      start = 1'b0;
      n_cmp++;
      if (difference !== 65'h1_0000_0000_0000_0001) begin
         n_bad++; $display("FAIL hold_in_calc: got %h expected %h", difference, 65'h1_0000_0000_0000_0001);
      end
      step();
      number1 = 64'd100; number2 = 64'd1; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (done) begin dn++; res = difference; end
         step();
      end
      n_cmp++;
      if (res !== 65'd6) begin
         n_bad++; $display("FAIL ignore_start result: got %h expected %h", res, 65'd6);
      end
      n_cmp++;
      if (dn !== 1) begin
         n_bad++; $display("FAIL ignore_start done_count: got %0d expected 1", dn);
      end
      check_op("after_ignore", 64'd100, 64'd1, 65'd99);
   endtask

   task automatic test_reset_mid();
      int dn = 0;
      number1 = 64'd50; number2 = 64'd8; start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst = 1'b1;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || difference !== 65'd0) begin
         n_bad++;
         $display("FAIL reset_mid: busy=%b done=%b diff=%h expected 0/0/0", busy, done, difference);
      end
      step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (done || busy) dn++;
         step();
      end
      n_cmp++;
      if (dn !== 0) begin
         n_bad++; $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", dn);
      end
      check_op("after_reset_7_7", 64'd7, 64'd7, 65'd0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_ignore_start();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sirali_cikarici.md
Name: sirali_cikarici

Overview:
- Multi-cycle unsigned 64-bit subtractor: difference = number1 - number2.
- Processes CHUNK bits per clock with a registered borrow chain.
- Complements the behavioural adder. It gives the datapath an area-cheap subtract path with a start/done handshake.
- Result is 65 bits, matching the adder's sum width. Bit 64 is the sign/borrow.

Parameters:
- WIDTH, 64: operand width. Result is WIDTH+1 bits.
- CHUNK, 16: bits subtracted per cycle. WIDTH % CHUNK must be 0 and 1 <= CHUNK <= WIDTH. Elaboration fails otherwise.
- NCHUNK (localparam), WIDTH/CHUNK: cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request. Sampled only in IDLE.
- number1  input  WIDTH  minuend. Latched when start is accepted.
- number2  input  WIDTH  subtrahend. Latched when start is accepted.
- busy  output  1  high while an operation is in progress (CALC)
- done  output  1  single-cycle pulse when difference is updated
- difference  output  WIDTH+1  {borrow_out, low WIDTH bits}. Two's-complement value of number1 - number2.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; busy=0, done=0, difference=0.
  - Operand registers, chunk counter, borrow and accumulator all cleared.
  - Reset mid-CALC aborts the operation; no done pulse follows.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at an edge latches number1/number2, cnt=0, borrow=0, goes to CALC.
  - busy rises after that edge.
  - start=0 stays in IDLE.
- CALC, each edge:
  - chunk i = cnt: {bo, d} = a[i*CHUNK +: CHUNK] - b[i*CHUNK +: CHUNK] - borrow.
  - d is written to acc[i*CHUNK +: CHUNK]; borrow <= bo; cnt <= cnt+1.
  - At the edge processing cnt==NCHUNK-1: difference <= {bo, acc with final chunk}, state -> DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - start is not honoured in DONE. It must be reasserted in IDLE.
- Latency:
  - start accepted at edge E0: result registered at edge E(NCHUNK); done high during the following cycle.
  - Defaults: done high 4 cycles after the accepting edge.
  - Back-to-back issue rate is one operation per NCHUNK+2 cycles.
- start while busy or in DONE: ignored. Operands are not re-latched; the in-flight result is unaffected.
- Input changes after acceptance have no effect.
- difference holds its last value through IDLE and CALC. It changes only at the CALC->DONE edge, or to 0 on reset.
- Arithmetic:
  - Unsigned operands; result is (number1 - number2) mod 2^(WIDTH+1).
  - bit WIDTH = 1 exactly when number1 < number2.
  - Equal operands give 0 with bit WIDTH = 0.
- Counter: width $clog2(NCHUNK), minimum 1. The counter does not wrap during a valid operation.
- CHUNK == WIDTH: a single CALC cycle; identical state sequence otherwise.
- done and busy are never high simultaneously.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2;
  - default WIDTH/CHUNK constants, shared with the adder benches.
- Sub-module cikarici_dilim: combinational CHUNK-bit subtract with borrow-in/borrow-out, instantiated once. Its parameter is CHUNK.

Test Plan:
- number1=3, number2=1, start pulse -> busy for 4 cycles; done pulses once; difference=65'd2.
- number1=1, number2=2 -> difference=65'h1_FFFF_FFFF_FFFF_FFFF (-1).
- number1=64'h0000_0000_0001_0000, number2=1 -> difference=65'h0_0000_0000_0000_FFFF (borrow propagates across a chunk boundary).
- number1=0, number2=64'hFFFF_FFFF_FFFF_FFFF -> difference=65'h1_0000_0000_0000_0001. Then number1=number2=64'hDEAD_BEEF_0000_0001 -> 65'd0.
- start with 10-4, then start again at the 2nd busy cycle with 100-1 -> second start ignored. Result 65'd6; exactly one done; a new start in IDLE then yields 65'd99.
- rst asserted during the 2nd CALC cycle -> busy, done and difference read 0 immediately, no done afterward; next operation 7-7 gives 65'd0 with normal latency.
